// File: rtl/encap_pkg.sv
// Shared McEliece parameter helpers and stream constants for the encap read-out path.
package encap_pkg;

  localparam logic [1:0] SEL_HDR = 2'd0;
  localparam logic [1:0] SEL_C0  = 2'd1;
  localparam logic [1:0] SEL_C1  = 2'd2;
  localparam logic [1:0] SEL_K   = 2'd3;

  localparam logic [7:0] HDR_MAGIC = 8'hA5;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    RD_C0,
    RD_C1,
    RD_K,
    DRAIN
  } state_e;

  typedef struct packed {
    logic [1:0]  sel;
    logic [31:0] data;
  } word_t;

  function automatic int set_n(input int ps);
    case (ps)
      1:       return 3488;
      2:       return 4608;
      3:       return 6688;
      4:       return 6960;
      default: return 8192;
    endcase
  endfunction

  function automatic int set_m(input int ps);
    return (ps == 1) ? 12 : 13;
  endfunction

  function automatic int set_t(input int ps);
    case (ps)
      1:       return 64;
      2:       return 96;
      3:       return 128;
      4:       return 119;
      default: return 128;
    endcase
  endfunction

  function automatic int set_l(input int ps);
    return set_m(ps) * set_t(ps);
  endfunction

  function automatic int c0_words(input int ps);
    return (set_l(ps) + 31) / 32;
  endfunction

endpackage

// File: rtl/word_skid_fifo.sv
// Two-entry data+tag FIFO; the head entry sits in a flop that drives the stream directly.
module word_skid_fifo
  import encap_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  word_t      din,
  input  logic       ready,
  output word_t      dout,
  output logic       valid,
  output logic       pop,
  output logic [1:0] occ
);

  word_t      out_q, out_d;
  word_t      skid_q, skid_d;
  logic [1:0] count_q, count_d;

  always_comb begin
    out_d   = out_q;
    skid_d  = skid_q;
    count_d = count_q;
    pop     = (count_q != 2'd0) && ready;
    case (count_q)
      2'd0: begin
        if (push) begin
          out_d   = din;
          count_d = 2'd1;
        end
      end
      2'd1: begin
        if (push && pop) begin
          out_d = din;
        end else if (pop) begin
          count_d = 2'd0;
        end else if (push) begin
          skid_d  = din;
          count_d = 2'd2;
        end
      end
      default: begin
        // Full: a push can only arrive together with a pop.
        if (pop) begin
          out_d = skid_q;
          if (push) skid_d = din;
          else count_d = 2'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q   <= '0;
      skid_q  <= '0;
      count_q <= 2'd0;
    end else begin
      out_q   <= out_d;
      skid_q  <= skid_d;
      count_q <= count_d;
    end
  end

  assign dout  = out_q;
  assign valid = (count_q != 2'd0);
  assign occ   = count_q;

endmodule

// File: rtl/encap_result_reader.sv
// Streams C0, C1 and K result words out of the encap core on a valid/ready port.
// Optional header word enabled by ENCAP_READER_HEADER_EN.
module encap_result_reader
  import encap_pkg::*;
#(
  parameter int parameter_set = 1,
  parameter int m             = set_m(parameter_set),
  parameter int t             = set_t(parameter_set),
  parameter int l             = m * t,
  parameter int C0_WORDS      = (l + 31) / 32,
  parameter int C0_AW         = $clog2(C0_WORDS),
  parameter int TOTAL_WORDS   = C0_WORDS + 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             rd_C0,
  output logic [C0_AW-1:0] C0_addr,
  input  logic [31:0]      C0_out,
  output logic             rd_C1,
  output logic [2:0]       C1_addr,
  input  logic [31:0]      C1_out,
  output logic             rd_K,
  output logic [2:0]       K_addr,
  input  logic [31:0]      K_out,
  output logic [31:0]      dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic [1:0]       dout_sel,
  output logic             dout_last
);

  localparam logic [C0_AW-1:0] C0_LAST = C0_AW'(C0_WORDS - 1);

  state_e           state_q, state_d;
  logic [C0_AW-1:0] c0_addr_q, c0_addr_d;
  logic [2:0]       c1_addr_q, c1_addr_d;
  logic [2:0]       k_addr_q, k_addr_d;
  logic [2:0]       kcnt_q, kcnt_d;
  logic [1:0]       infl_sel_q, infl_sel_d;
  logic             infl_q, infl_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             issue, push, pop, reading;
  logic [1:0]       occ, occ_eff;
  logic [2:0]       pending;
  logic [31:0]      rd_data, hdr_word;
  word_t            fifo_in, fifo_out;

  assign hdr_word = {HDR_MAGIC, 8'(parameter_set), 16'(TOTAL_WORDS)};

  always_comb begin
    case (infl_sel_q)
      SEL_C0:  rd_data = C0_out;
      SEL_C1:  rd_data = C1_out;
      default: rd_data = K_out;
    endcase
  end

  // A word leaving this cycle frees its slot for a new read.
  assign occ_eff = occ - {1'b0, pop};
  assign pending = {1'b0, occ_eff} + {2'b0, infl_q};
  assign reading = (state_q == RD_C0) || (state_q == RD_C1) || (state_q == RD_K);
  assign issue   = reading && (pending < 3'd2);
  assign push    = infl_q || (state_q == HDR);

  always_comb begin
    fifo_in.sel  = infl_q ? infl_sel_q : SEL_HDR;
    fifo_in.data = infl_q ? rd_data : hdr_word;
  end

  always_comb begin
    state_d    = state_q;
    c0_addr_d  = c0_addr_q;
    c1_addr_d  = c1_addr_q;
    k_addr_d   = k_addr_q;
    kcnt_d     = kcnt_q;
    infl_d     = issue;
    infl_sel_d = infl_sel_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    rd_C0      = 1'b0;
    rd_C1      = 1'b0;
    rd_K       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          busy_d  = 1'b1;
`ifdef ENCAP_READER_HEADER_EN
          state_d = HDR;
`else
          state_d = RD_C0;
`endif
        end
      end
      HDR: state_d = RD_C0;
      RD_C0: begin
        if (issue) begin
          rd_C0      = 1'b1;
          infl_sel_d = SEL_C0;
          if (c0_addr_q == C0_LAST) begin
            c0_addr_d = '0;
            state_d   = RD_C1;
          end else begin
            c0_addr_d = c0_addr_q + C0_AW'(1);
          end
        end
      end
      RD_C1: begin
        if (issue) begin
          rd_C1      = 1'b1;
          infl_sel_d = SEL_C1;
          c1_addr_d  = c1_addr_q + 3'd1;
          if (c1_addr_q == 3'd7) state_d = RD_K;
        end
      end
      RD_K: begin
        if (issue) begin
          rd_K       = 1'b1;
          infl_sel_d = SEL_K;
          k_addr_d   = k_addr_q + 3'd1;
          if (k_addr_q == 3'd7) state_d = DRAIN;
        end
      end
      DRAIN: begin
        // Leave only after done has pulsed so start can never meet done.
        if (done_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (pop && fifo_out.sel == SEL_K) kcnt_d = kcnt_q + 3'd1;
    if (pop && dout_last) begin
      done_d = 1'b1;
      busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      c0_addr_q  <= '0;
      c1_addr_q  <= 3'd0;
      k_addr_q   <= 3'd0;
      kcnt_q     <= 3'd0;
      infl_q     <= 1'b0;
      infl_sel_q <= SEL_HDR;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      c0_addr_q  <= c0_addr_d;
      c1_addr_q  <= c1_addr_d;
      k_addr_q   <= k_addr_d;
      kcnt_q     <= kcnt_d;
      infl_q     <= infl_d;
      infl_sel_q <= infl_sel_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  word_skid_fifo u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (fifo_in),
    .ready (dout_ready),
    .dout  (fifo_out),
    .valid (dout_valid),
    .pop   (pop),
    .occ   (occ)
  );

  assign busy      = busy_q;
  assign done      = done_q;
  assign C0_addr   = c0_addr_q;
  assign C1_addr   = c1_addr_q;
  assign K_addr    = k_addr_q;
  assign dout      = fifo_out.data;
  assign dout_sel  = fifo_out.sel;
  assign dout_last = dout_valid && (fifo_out.sel == SEL_K) && (kcnt_q == 3'd7);

endmodule
